// File: rtl/cdac_load_ctrl.sv
// Comparator threshold DAC loader: shifts a WIDTH-bit word MSB first on the DAC
// serial pins, restores DEF_VALUE after reset and yields the pins to JTAG on demand.
//   state | meaning
//   IDLE  | no frame on the pins; starts one when a word is pending and JTAG is idle
//   LO    | DACCLK low half period, current bit already on DACDAT
//   HI    | DACCLK high half period, DAC samples the bit on the rise
//   HOLD  | enable still low after the last bit, DACCLK low
//   GUARD | enable high for one half period before a new frame may start
module cdac_load_ctrl #(
  parameter int               WIDTH       = 12,
  parameter int               HALF_PER    = 2,
  parameter logic [WIDTH-1:0] DEF_VALUE   = 12'h800,
  parameter bit               LOAD_ON_RST = 1'b1
) (
  input  logic             CLK25,
  input  logic             RST,
  input  logic             LOAD_REQ,
  input  logic [WIDTH-1:0] DAC_WORD,
  input  logic             JTAG_ENA,
  input  logic             JTAG_CLK,
  input  logic             JTAG_DAT,
  output logic             DACCLK,
  output logic             DACDAT,
  output logic             DAC_ENB_B,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORT,
  output logic [WIDTH-1:0] CUR_VALUE
);

  localparam int PW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [PW-1:0] PH_TC  = PW'(HALF_PER - 1);
  localparam logic [BW-1:0] BIT_TC = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LO, HI, HOLD, GUARD} state_t;

  state_t           state;
  logic [PW-1:0]    ph_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-2:0] shift_reg;
  logic [WIDTH-1:0] frame_word;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] cur_value;
  logic             pending;
  logic             clk_r;
  logic             dat_r;
  logic             enb_r;
  logic             done_r;
  logic             abort_r;
  logic             ph_tc;
  logic             frame_active;

  assign ph_tc        = (ph_cnt == '0);
  assign frame_active = (state == LO) || (state == HI) || (state == HOLD);

  always_ff @(posedge CLK25) begin
    if (RST) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      frame_word <= DEF_VALUE;
      shadow     <= DEF_VALUE;
      cur_value  <= DEF_VALUE;
      pending    <= LOAD_ON_RST;
      clk_r      <= 1'b0;
      dat_r      <= 1'b0;
      enb_r      <= 1'b1;
      done_r     <= 1'b0;
      abort_r    <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      if (frame_active && JTAG_ENA) begin
        // JTAG took the pins: drop the frame and re-run it from the MSB later
        state   <= IDLE;
        abort_r <= 1'b1;
        pending <= 1'b1;
        clk_r   <= 1'b0;
        dat_r   <= 1'b0;
        enb_r   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (pending && !JTAG_ENA) begin
              state      <= LO;
              ph_cnt     <= PH_TC;
              bit_cnt    <= BIT_TC;
              shift_reg  <= shadow[WIDTH-2:0];
              frame_word <= shadow;
              pending    <= 1'b0;
              enb_r      <= 1'b0;
              dat_r      <= shadow[WIDTH-1];
              clk_r      <= 1'b0;
            end
          end
          LO: begin
            if (ph_tc) begin
              state  <= HI;
              clk_r  <= 1'b1;
              ph_cnt <= PH_TC;
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end
          HI: begin
            if (ph_tc) begin
              clk_r  <= 1'b0;
              ph_cnt <= PH_TC;
              if (bit_cnt == '0) begin
                state <= HOLD;
              end else begin
                state     <= LO;
                bit_cnt   <= bit_cnt - 1'b1;
                dat_r     <= shift_reg[WIDTH-2];
                shift_reg <= {shift_reg[WIDTH-3:0], 1'b0};
              end
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end
          HOLD: begin
            if (ph_tc) begin
              state     <= GUARD;
              ph_cnt    <= PH_TC;
              enb_r     <= 1'b1;
              dat_r     <= 1'b0;
              done_r    <= 1'b1;
              cur_value <= frame_word;
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end
          GUARD: begin
            if (ph_tc) begin
              state <= IDLE;
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
      // Placed last so a request always outlives the pending clear of a frame start
      if (LOAD_REQ) begin
        shadow  <= DAC_WORD;
        pending <= 1'b1;
      end
    end
  end

  assign DACCLK    = JTAG_ENA ? JTAG_CLK : clk_r;
  assign DACDAT    = JTAG_ENA ? JTAG_DAT : dat_r;
  assign DAC_ENB_B = JTAG_ENA ? 1'b0     : enb_r;
  assign BUSY      = pending | (state != IDLE);
  assign DONE      = done_r;
  assign ABORT     = abort_r;
  assign CUR_VALUE = cur_value;

endmodule

// File: tb/tb_cdac_load_ctrl.sv
// Bench for cdac_load_ctrl: two instances (HALF_PER 2 and 1) against a timed frame model.
module tb_cdac_load_ctrl;
  localparam int W = 12;
  localparam logic [W-1:0] DEF = 12'h800;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic         rst = 1'b1, load_req = 1'b0, jena = 1'b0, jclk = 1'b0, jdat = 1'b0;
  logic [W-1:0] word = '0;

  logic         dclk [2], ddat [2], denb [2], busy [2], done [2], abort [2];
  logic [W-1:0] cur  [2];

  cdac_load_ctrl #(.WIDTH(W), .HALF_PER(2), .DEF_VALUE(DEF), .LOAD_ON_RST(1'b1)) u0 (
    .CLK25(clk), .RST(rst), .LOAD_REQ(load_req), .DAC_WORD(word), .JTAG_ENA(jena),
    .JTAG_CLK(jclk), .JTAG_DAT(jdat), .DACCLK(dclk[0]), .DACDAT(ddat[0]),
    .DAC_ENB_B(denb[0]), .BUSY(busy[0]), .DONE(done[0]), .ABORT(abort[0]),
    .CUR_VALUE(cur[0]));

  cdac_load_ctrl #(.WIDTH(W), .HALF_PER(1), .DEF_VALUE(DEF), .LOAD_ON_RST(1'b1)) u1 (
    .CLK25(clk), .RST(rst), .LOAD_REQ(load_req), .DAC_WORD(word), .JTAG_ENA(jena),
    .JTAG_CLK(jclk), .JTAG_DAT(jdat), .DACCLK(dclk[1]), .DACDAT(ddat[1]),
    .DAC_ENB_B(denb[1]), .BUSY(busy[1]), .DONE(done[1]), .ABORT(abort[1]),
    .CUR_VALUE(cur[1]));

  int n_assert = 0;
  int n_fail   = 0;

  // Frame model: k counts cycles since the enable fell; everything else follows by arithmetic
  int           hp [2] = '{2, 1};
  bit           m_act [2], m_pend [2], m_done [2], m_abort [2];
  int           m_k [2], m_guard [2];
  logic [W-1:0] m_shadow [2], m_cur [2], m_fw [2];

  // Pin-level observation of u0
  logic         prev_clk0 = 1'b0;
  logic [W-1:0] cap;
  int           ncap, done_cnt, abort_cnt, enb_low, cyc, first_done;
  logic [W-1:0] done_words [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d);
    int h;
    h = hp[d];
    if (rst) begin
      m_act[d] = 0; m_k[d] = 0; m_guard[d] = 0; m_done[d] = 0; m_abort[d] = 0;
      m_pend[d] = 1; m_shadow[d] = DEF; m_cur[d] = DEF;
    end else begin
      m_done[d] = 0; m_abort[d] = 0;
      if (m_act[d] && jena) begin
        m_act[d] = 0; m_abort[d] = 1; m_pend[d] = 1;
      end else if (m_act[d]) begin
        m_k[d]++;
        if (m_k[d] == 2*W*h + h) begin
          m_act[d] = 0; m_done[d] = 1; m_cur[d] = m_fw[d]; m_guard[d] = h;
        end
      end else if (m_guard[d] > 0) begin
        m_guard[d]--;
      end else if (m_pend[d] && !jena) begin
        m_act[d] = 1; m_k[d] = 0; m_fw[d] = m_shadow[d]; m_pend[d] = 0;
      end
      if (load_req) begin
        m_shadow[d] = word; m_pend[d] = 1;
      end
    end
  endtask

  task automatic check_dut(input int d);
    int   h;
    logic ec, ed, ee;
    bit   dat_known;
    h = hp[d];
    dat_known = 0; ed = 1'b0;
    if (jena) begin
      ec = jclk; ed = jdat; ee = 1'b0; dat_known = 1;
    end else if (m_act[d] && m_k[d] < 2*W*h) begin
      ec = ((m_k[d] / h) % 2) == 1;
      ed = m_fw[d][W-1 - m_k[d]/(2*h)];
      ee = 1'b0; dat_known = 1;
    end else if (m_act[d]) begin
      ec = 1'b0; ee = 1'b0;
    end else begin
      ec = 1'b0; ee = 1'b1;
    end
    chk($sformatf("u%0d_dacclk", d), 32'(dclk[d]), 32'(ec));
    chk($sformatf("u%0d_enb_b", d), 32'(denb[d]), 32'(ee));
    if (dat_known) chk($sformatf("u%0d_dacdat", d), 32'(ddat[d]), 32'(ed));
    chk($sformatf("u%0d_busy", d), 32'(busy[d]),
        32'(m_pend[d] || m_act[d] || (m_guard[d] > 0)));
    chk($sformatf("u%0d_done", d), 32'(done[d]), 32'(m_done[d]));
    chk($sformatf("u%0d_abort", d), 32'(abort[d]), 32'(m_abort[d]));
    chk($sformatf("u%0d_cur", d), 32'(cur[d]), 32'(m_cur[d]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    cyc++;
    if (!jena && !denb[0] && dclk[0] && !prev_clk0) begin
      cap = {cap[W-2:0], ddat[0]};
      ncap++;
    end
    prev_clk0 = dclk[0];
    if (!jena && !denb[0]) enb_low++;
    if (done[0]) begin
      done_cnt++;
      done_words.push_back(cur[0]);
      if (first_done < 0) first_done = cyc;
    end
    if (abort[0]) abort_cnt++;
  endtask

  task automatic clear_obs();
    cap = '0; ncap = 0; done_cnt = 0; abort_cnt = 0; enb_low = 0; cyc = 0; first_done = -1;
    done_words.delete();
  endtask

  task automatic load(input logic [W-1:0] w);
    word = w; load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int jb;
    clear_obs();
    // Reset state
    rst = 1'b1;
    run(3);
    chk("rst_enb_b", 32'(denb[0]), 32'd1);
    chk("rst_dacclk", 32'(dclk[0]), 32'd0);
    chk("rst_cur", 32'(cur[0]), 32'(DEF));

    // Default frame after reset release
    rst = 1'b0;
    clear_obs();
    run(70);
    chk("def_done_cycle", 32'(first_done), 32'd51);
    chk("def_rises", 32'(ncap), 32'(W));
    chk("def_bits", 32'(cap), 32'(DEF));

    // Ordinary load
    clear_obs();
    load(12'hA5C);
    run(70);
    chk("a5c_bits", 32'(cap), 32'h0A5C);
    chk("a5c_enb_low", 32'(enb_low), 32'd50);
    chk("a5c_done_cnt", 32'(done_cnt), 32'd1);
    chk("a5c_cur", 32'(cur[0]), 32'h0A5C);

    // JTAG takeover after five bits, then full re-run
    clear_obs();
    load(12'h3FF);
    for (int i = 0; i < 200 && ncap < 5; i++) step();
    chk("abort_wait_rises", 32'(ncap), 32'd5);
    jena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      jclk = 1'($urandom_range(0, 1));
      jdat = 1'($urandom_range(0, 1));
      step();
      if (i == 0) chk("abort_pulse", 32'(abort[0]), 32'd1);
    end
    chk("abort_cnt", 32'(abort_cnt), 32'd1);
    chk("abort_cur_kept", 32'(cur[0]), 32'h0A5C);
    jena = 1'b0; jclk = 1'b0; jdat = 1'b0;
    clear_obs();
    run(70);
    chk("rerun_rises", 32'(ncap), 32'(W));
    chk("rerun_bits", 32'(cap), 32'h03FF);
    chk("rerun_cur", 32'(cur[0]), 32'h03FF);

    // Last request wins
    clear_obs();
    load(12'h111);
    run(10);
    load(12'h222);
    run(3);
    load(12'h333);
    run(160);
    chk("lrw_frames", 32'(done_words.size()), 32'd2);
    if (done_words.size() == 2) begin
      chk("lrw_first", 32'(done_words[0]), 32'h0111);
      chk("lrw_second", 32'(done_words[1]), 32'h0333);
    end

    // Request queued while JTAG owns the pins
    jena = 1'b1;
    load(12'h0F0);
    run(5);
    jena = 1'b0;
    run(70);
    chk("jtag_queued_cur", 32'(cur[0]), 32'h00F0);

    // Reset mid-frame
    load(12'h5A5);
    run(20);
    rst = 1'b1;
    step();
    chk("midrst_enb_b", 32'(denb[0]), 32'd1);
    chk("midrst_dacclk", 32'(dclk[0]), 32'd0);
    chk("midrst_cur", 32'(cur[0]), 32'(DEF));
    rst = 1'b0;
    clear_obs();
    run(70);
    chk("midrst_frames", 32'(done_words.size()), 32'd1);
    chk("midrst_bits", 32'(cap), 32'(DEF));

    // Random traffic against the model
    jb = 0;
    for (int i = 0; i < 3000; i++) begin
      if (jb > 0) jb--;
      else if ($urandom_range(0, 149) == 0) jb = int'($urandom_range(1, 30));
      jena     = (jb > 0);
      jclk     = 1'($urandom_range(0, 1));
      jdat     = 1'($urandom_range(0, 1));
      load_req = ($urandom_range(0, 24) == 0);
      word     = 12'($urandom);
      rst      = ($urandom_range(0, 1499) == 0);
      step();
    end
    jena = 1'b0; load_req = 1'b0; rst = 1'b0; jclk = 1'b0; jdat = 1'b0;
    run(200);
    chk("drain_busy0", 32'(busy[0]), 32'd0);
    chk("drain_busy1", 32'(busy[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
